// File: rtl/ssd_scan_counter.sv
// Four-digit BCD event counter with a time-multiplexed, frame-coherent display scanner.
// Optional macro SSD_LEADING_ZERO_BLANK_EN suppresses leading-zero digits 1..3.
module ssd_scan_counter #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_inc,
  input  logic        cnt_clr,
  output logic [15:0] value_o,
  output logic        carry_o,
  output logic [3:0]  bcd_o,
  output logic [3:0]  dig_sel_n
);

  localparam int PRE_W = 16;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);

  logic [15:0]      count_q, count_d;
  logic             carry_q, carry_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       bcd_q, bcd_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       suppress;
  logic             ripple;
  logic             slotWrap;
  logic             frameWrap;

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ripple  = 1'b0;
    if (cnt_clr) begin
      count_d = 16'h0000;
    end else if (cnt_inc) begin
      ripple = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (ripple) begin
          // A digit at 9 (or any out-of-range value) rolls to 0 and keeps the carry going.
          if (count_q[4*k +: 4] >= 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end
      end
      carry_d = ripple;
    end
  end

  // Display outputs are registered from next-state values so they line up with pre/idx.
  always_comb begin
    slotWrap  = (pre_q == PRE_LAST);
    frameWrap = slotWrap && (idx_q == 2'd3);
    pre_d     = slotWrap ? '0 : pre_q + PRE_W'(1);
    idx_d     = slotWrap ? idx_q + 2'd1 : idx_q;
    snap_d    = frameWrap ? count_q : snap_q;
    bcd_d     = snap_d[{idx_d, 2'b00} +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
    suppress[0] = 1'b0;
    suppress[1] = (snap_d[15:4]  == 12'h000);
    suppress[2] = (snap_d[15:8]  == 8'h00);
    suppress[3] = (snap_d[15:12] == 4'h0);
`else
    suppress = 4'b0000;
`endif
    sel_d = 4'hF;
    if ((pre_d >= PRE_BLANK) && !suppress[idx_d]) begin
      sel_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
      carry_q <= 1'b0;
      pre_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      bcd_q   <= 4'h0;
      sel_q   <= 4'hF;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      sel_q   <= sel_d;
    end
  end

  assign value_o   = count_q;
  assign carry_o   = carry_q;
  assign bcd_o     = bcd_q;
  assign dig_sel_n = sel_q;

endmodule
